// File: rtl/button_conditioner.sv
// Four-button front end: synchronise, debounce and reduce to a one-hot (or zero)
// level with a press strobe, rejecting any multi-button condition.
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn,
  output logic       press_pulse,
  output logic [1:0] press_id,
  output logic       multi_err,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  sync;
  logic [3:0]                  db_q, db_d;
  logic [3:0][CW-1:0]          cnt_q, cnt_d;
  state_t                      state_q, state_d;
  logic [3:0]                  btn_q, btn_d;
  logic [1:0]                  press_id_q, press_id_d;
  logic                        press_pulse_q, press_pulse_d;
  logic                        multi_err_q, multi_err_d;
  logic [2:0]                  popcnt;
  logic [1:0]                  enc;

  // Plain shift chain: stage 0 is the only flop that sees the raw pins.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    sync   = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = sync[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      db_q   <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    popcnt = 3'd0;
    enc    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      popcnt = popcnt + {2'b00, db_q[i]};
      if (db_q[i]) enc = 2'(i);
    end
  end

  // State register; the registered outputs share its reset and clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      btn_q         <= '0;
      press_id_q    <= '0;
      press_pulse_q <= 1'b0;
      multi_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_q         <= btn_d;
      press_id_q    <= press_id_d;
      press_pulse_q <= press_pulse_d;
      multi_err_q   <= multi_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (popcnt == 3'd1)      state_d = S_PRESS;
        else if (popcnt >= 3'd2) state_d = S_LOCK;
      end
      S_PRESS: begin
        if (db_q == 4'd0)       state_d = S_IDLE;
        else if (db_q != btn_q) state_d = S_LOCK;
      end
      S_LOCK: begin
        if (db_q == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // press_id is only rewritten on an accepted press so it holds while idle.
  always_comb begin
    btn_d         = btn_q;
    press_id_d    = press_id_q;
    press_pulse_d = 1'b0;
    multi_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (popcnt == 3'd1) begin
          btn_d         = db_q;
          press_id_d    = enc;
          press_pulse_d = 1'b1;
        end else if (popcnt >= 3'd2) begin
          multi_err_d = 1'b1;
        end
      end
      S_PRESS: begin
        if (db_q == 4'd0) begin
          btn_d = 4'd0;
        end else if (db_q != btn_q) begin
          btn_d       = 4'd0;
          multi_err_d = 1'b1;
        end
      end
      default: btn_d = 4'd0;
    endcase
  end

  assign btn         = btn_q;
  assign press_pulse = press_pulse_q;
  assign press_id    = press_id_q;
  assign multi_err   = multi_err_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Front-end stage that feeds the one-hot `btn` bus into the game top level. It takes the four raw, asynchronous, bouncing push-button inputs and does three things: synchronises each input into the `clk` domain, debounces each one independently, and produces a clean level that is strictly one-hot (or zero). It also produces a single-cycle press strobe with an encoded button id. Multi-button presses are rejected and flagged, so the downstream decoder never sees an invalid pattern.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchroniser chain (minimum 2).
- DEBOUNCE_CYCLES, 1000000, consecutive `clk` cycles a synchronised input must differ from its stable value before the change is accepted (10 ms at 100 MHz). Minimum 2.

Ports:
- clk  in  1  100 MHz system clock; all flops are rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- btn_raw  in  4  raw button pins, asynchronous, 1 = pressed, bouncing.
- btn  out  4  conditioned one-hot level; 0000 when idle, rejected or locked out.
- press_pulse  out  1  one-cycle strobe on each accepted single press.
- press_id  out  2  index of the accepted button (bit 0 -> 0 ... bit 3 -> 3); valid whenever `btn` is nonzero.
- multi_err  out  1  one-cycle strobe when a multi-button condition is detected.

Behaviour:
- Reset (reset = 0, asynchronous):
  - All synchroniser flops, debounce counters, stable registers, the FSM state and every output clear to 0.
  - State returns to IDLE.
  - Takes effect without a clock edge.
- Synchroniser: per bit, a SYNC_STAGES-deep flop chain. `sync[i]` is the last stage. No logic sits between the stages.
- Debouncer, per bit i, with stable register `db[i]` and counter `cnt[i]`:
  - If `sync[i] == db[i]`, then `cnt[i]` <= 0.
  - Otherwise, if `cnt[i] == DEBOUNCE_CYCLES-1`, then `db[i]` <= `sync[i]` and `cnt[i]` <= 0.
  - Otherwise, `cnt[i]` <= `cnt[i]` + 1.
  - Counter width is ceil(log2(DEBOUNCE_CYCLES)). The counter never wraps, because it clears on reaching terminal count.
  - Any bounce back to the stable value restarts the count.
- FSM on `db[3:0]`. Outputs are registered. `popcnt` = number of set bits in `db`.
  - IDLE (`btn` = 0):
    - `db` == 0: stay.
    - `popcnt` == 1: go to PRESS; `btn` <= `db`; `press_id` <= encode(`db`); `press_pulse` <= 1 for one cycle.
    - `popcnt` >= 2: go to LOCK; `multi_err` <= 1 for one cycle.
  - PRESS (`btn` holds the latched one-hot value):
    - `db` == `btn`: stay.
    - `db` == 0: go to IDLE; `btn` <= 0.
    - Any other `db` (button added or switched): go to LOCK; `btn` <= 0; `multi_err` pulse.
  - LOCK (`btn` = 0, no pulses):
    - Leave only when `db` == 0, going to IDLE.
    - Partial release does not re-arm.
  - `press_id` holds its last value when `btn` = 0.
  - `press_pulse` and `multi_err` are never asserted in the same cycle.
- Latency: raw edge to `btn`/`press_pulse` change is SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising edges, with the raw input held stable throughout. Release latency is identical.
- Simultaneous `db` updates on several bits in the same cycle are evaluated as one pattern. Two bits rising together go IDLE -> LOCK with no press accepted.
- Reset mid-press: outputs clear immediately.
  - A button still held at reset release is debounced from `db` = 0.
  - It is accepted as a new press after the full latency, with exactly one `press_pulse`.
- No combinational path from `btn_raw` to any output.

Test Plan:
All scenarios use SYNC_STAGES = 2 and DEBOUNCE_CYCLES = 4, giving a latency of 7 edges.
- Clean press: `btn_raw` 0000 -> 0010 held 20 cycles -> `btn` = 0010 and `press_pulse` = 1 on the 7th edge. `press_pulse` is 0 on the 8th edge. `press_id` = 1. Release -> `btn` = 0000 on the 7th edge after release.
- Bounce rejection: `btn_raw[0]` toggles every 2 cycles for 12 cycles, then stays 0 -> `btn` stays 0000; `press_pulse` and `multi_err` never assert.
- Simultaneous multi-press: `btn_raw` 0000 -> 0101 -> `multi_err` single pulse on the 7th edge; `btn` stays 0000. Release to 0000, then 1000 -> normal press with `press_id` = 3 and one `press_pulse`.
- Added button during press: 0001 held, then 0101 -> `btn` drops to 0000 with one `multi_err` pulse. Then 0001 (partial release) -> `btn` stays 0000 (LOCK). Then 0000, then 0001 -> a new press is accepted.
- Async reset mid-press: while `btn` = 0010, drive `reset` = 0 between clock edges -> all outputs are 0 before the next edge. Release reset with 0010 still held -> `btn` = 0010 with one `press_pulse` 7 edges later.
- Repeated press: press 0100, release, press 0100 again (each phase held 15 cycles) -> exactly two `press_pulse`s, `press_id` = 2 both times, `multi_err` never asserts.
